pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipelined CPU (Fetch/Decode/Execute/Memory/WriteBack). It generalises the existing hazard unit with three additions: a variable-latency data-memory handshake with a wait-state FSM and timeout, a per-stage stall/flush vector covering all four pipeline registers, and optional performance counters. It sits beside the datapath and drives the enables and clears of every pipeline flip-flop plus the Execute forwarding muxes.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_forward_select.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the pipelined CPU control path.
// Covers the forwarding mux encoding and the data-memory wait FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_select.sv
// Forwarding comparator for one Execute source operand.
// The M stage wins over WB because it holds the younger result.
module forward_select
    import cpu_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int HARDZERO     = 0
) (
    input  logic [ADDRESSWIDTH-1:0] src_addr,
    input  logic [ADDRESSWIDTH-1:0] dest_addr_m,
    input  logic                    write_en_m,
    input  logic [ADDRESSWIDTH-1:0] dest_addr_wb,
    input  logic                    write_en_wb,
    output logic [1:0]              fwd_sel
);

    fwd_sel_t sel;
    logic     src_is_zero;

    assign src_is_zero = (HARDZERO != 0) && (src_addr == '0);

    always_comb begin
        sel = FWD_REG;
        if (!src_is_zero) begin
            if (write_en_m && (dest_addr_m == src_addr)) begin
                sel = FWD_M;
            end else if (write_en_wb && (dest_addr_wb == src_addr)) begin
                sel = FWD_WB;
            end
        end
    end

    assign fwd_sel = sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: forwarding, load-use, branch flush, memory wait with timeout.
// Optional saturating perf counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNTWIDTH     = 16,
    parameter int HARDZERO     = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressD,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressD,
    input  logic                    useReg1D,
    input  logic                    useReg2D,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressE,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressE,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressE,
    input  logic                    writeEnableE,
    input  logic                    isLoadE,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressM,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressWB,
    input  logic                    writeEnableM,
    input  logic                    writeEnableWB,
    input  logic                    memReqM,
    input  logic                    memReadyM,
    input  logic                    takeBranchE,
    output logic [1:0]              data1ForwardSelectorE,
    output logic [1:0]              data2ForwardSelectorE,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    stallE,
    output logic                    stallM,
    output logic                    flushD,
    output logic                    flushE,
    output logic                    flushWB,
    output logic                    memError,
    output logic [CNTWIDTH-1:0]     stallCount,
    output logic [CNTWIDTH-1:0]     flushCount
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    mem_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  mem_error_q, mem_error_d;
    logic                  timeout, mem_stall, lw_hit, lw_stall, branch_flush;
    logic                  unused_write_enable_e;

    // A load always writes its destination, so the hazard keys on isLoadE alone.
    assign unused_write_enable_e = writeEnableE;

    forward_select #(.ADDRESSWIDTH(ADDRESSWIDTH), .HARDZERO(HARDZERO)) u_fwd1 (
        .src_addr     (reg1AddressE),
        .dest_addr_m  (regDestinationAddressM),
        .write_en_m   (writeEnableM),
        .dest_addr_wb (regDestinationAddressWB),
        .write_en_wb  (writeEnableWB),
        .fwd_sel      (data1ForwardSelectorE)
    );

    forward_select #(.ADDRESSWIDTH(ADDRESSWIDTH), .HARDZERO(HARDZERO)) u_fwd2 (
        .src_addr     (reg2AddressE),
        .dest_addr_m  (regDestinationAddressM),
        .write_en_m   (writeEnableM),
        .dest_addr_wb (regDestinationAddressWB),
        .write_en_wb  (writeEnableWB),
        .fwd_sel      (data2ForwardSelectorE)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MEM_IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign timeout = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        case (state_q)
            MEM_IDLE: begin
                if (memReqM && !memReadyM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (memReadyM) begin
                    state_d = MEM_IDLE;
                end else if (timeout) begin
                    state_d     = MEM_IDLE;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // The IDLE term stalls the first cycle of a slow access before the FSM has moved.
    always_comb begin
        mem_stall = ((state_q == MEM_IDLE) && memReqM && !memReadyM)
                  || ((state_q == MEM_WAIT) && !memReadyM && !timeout);
        lw_hit    = isLoadE
                  && !((HARDZERO != 0) && (regDestinationAddressE == '0))
                  && ((useReg1D && (regDestinationAddressE == reg1AddressD))
                   || (useReg2D && (regDestinationAddressE == reg2AddressD)));
        lw_stall     = lw_hit && !mem_stall;
        branch_flush = takeBranchE && !mem_stall;

        stallF   = mem_stall || (lw_stall && !branch_flush);
        stallD   = mem_stall || (lw_stall && !branch_flush);
        stallE   = mem_stall;
        stallM   = mem_stall;
        flushD   = branch_flush;
        flushE   = branch_flush || lw_stall;
        flushWB  = mem_stall;
        memError = mem_error_q;
    end

`ifdef HAZARD_PERF_EN
    logic [CNTWIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNTWIDTH-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stallD && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNTWIDTH'(1);
        end
        if ((flushD || flushE) && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNTWIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;
`else
    assign stallCount = '0;
    assign flushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
// Each step pushes its expected outputs, then pops and compares them mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam int AW  = 4;
    localparam int TMO = 4;
    localparam int CW  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] reg1AddressD, reg2AddressD, reg1AddressE, reg2AddressE;
    logic [AW-1:0] regDestinationAddressE, regDestinationAddressM, regDestinationAddressWB;
    logic          useReg1D, useReg2D, writeEnableE, isLoadE, writeEnableM, writeEnableWB;
    logic          memReqM, memReadyM, takeBranchE;
    logic [1:0]    data1ForwardSelectorE, data2ForwardSelectorE;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushWB, memError;
    logic [CW-1:0] stallCount, flushCount;

    typedef struct {
        string      tag;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [3:0] stl;
        logic [2:0] fls;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall_cnt = 0;
    int   exp_flush_cnt = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(
        .ADDRESSWIDTH(AW), .MEM_TIMEOUT(TMO), .CNTWIDTH(CW), .HARDZERO(0)
    ) dut (
        .clock(clock), .reset(reset),
        .reg1AddressD(reg1AddressD), .reg2AddressD(reg2AddressD),
        .useReg1D(useReg1D), .useReg2D(useReg2D),
        .reg1AddressE(reg1AddressE), .reg2AddressE(reg2AddressE),
        .regDestinationAddressE(regDestinationAddressE),
        .writeEnableE(writeEnableE), .isLoadE(isLoadE),
        .regDestinationAddressM(regDestinationAddressM),
        .regDestinationAddressWB(regDestinationAddressWB),
        .writeEnableM(writeEnableM), .writeEnableWB(writeEnableWB),
        .memReqM(memReqM), .memReadyM(memReadyM), .takeBranchE(takeBranchE),
        .data1ForwardSelectorE(data1ForwardSelectorE),
        .data2ForwardSelectorE(data2ForwardSelectorE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushWB(flushWB),
        .memError(memError), .stallCount(stallCount), .flushCount(flushCount)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idleInputs();
        reg1AddressD = '0; reg2AddressD = '0; useReg1D = 1'b0; useReg2D = 1'b0;
        reg1AddressE = '0; reg2AddressE = '0; regDestinationAddressE = '0;
        writeEnableE = 1'b0; isLoadE = 1'b0;
        regDestinationAddressM = '0; regDestinationAddressWB = '0;
        writeEnableM = 1'b0; writeEnableWB = 1'b0;
        memReqM = 1'b0; memReadyM = 1'b0; takeBranchE = 1'b0;
    endtask

    // Counters hold the tally of earlier cycles; this cycle's events land at the next edge.
    task automatic checkOutput();
        exp_t e;
        int   exp_sc, exp_fc;
        e = sb_q.pop_front();
        if (!reset) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end
`ifdef HAZARD_PERF_EN
        exp_sc = exp_stall_cnt;
        exp_fc = exp_flush_cnt;
`else
        exp_sc = 0;
        exp_fc = 0;
`endif
        cmp({e.tag, "/fwd1"}, 32'(data1ForwardSelectorE), 32'(e.f1));
        cmp({e.tag, "/fwd2"}, 32'(data2ForwardSelectorE), 32'(e.f2));
        cmp({e.tag, "/stallFDEM"}, 32'({stallF, stallD, stallE, stallM}), 32'(e.stl));
        cmp({e.tag, "/flushDEWB"}, 32'({flushD, flushE, flushWB}), 32'(e.fls));
        cmp({e.tag, "/memError"}, 32'(memError), 32'(e.err));
        cmp({e.tag, "/stallCount"}, 32'(stallCount), 32'(exp_sc));
        cmp({e.tag, "/flushCount"}, 32'(flushCount), 32'(exp_fc));
        if (reset) begin
            if (e.stl[2]) exp_stall_cnt++;
            if (e.fls[2] || e.fls[1]) exp_flush_cnt++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                                 input logic [3:0] stl, input logic [2:0] fls, input logic err);
        exp_t e;
        e.tag = tag; e.f1 = f1; e.f2 = f2; e.stl = stl; e.fls = fls; e.err = err;
        sb_q.push_back(e);
        #3;
        checkOutput();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idleInputs();
        reset = 1'b0;
        @(posedge clock);
        #1;
        applyStimulus("reset_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        reset = 1'b1;
        applyStimulus("idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

        writeEnableM = 1'b1; regDestinationAddressM = 4'd3; reg1AddressE = 4'd3; reg2AddressE = 4'd4;
        applyStimulus("fwd_m", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0);
        writeEnableM = 1'b0; writeEnableWB = 1'b1; regDestinationAddressWB = 4'd3;
        applyStimulus("fwd_wb", 2'b01, 2'b00, 4'b0000, 3'b000, 1'b0);
        writeEnableM = 1'b1;
        applyStimulus("fwd_m_over_wb", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0);
        reg2AddressE = 4'd3;
        applyStimulus("fwd_both_src", 2'b10, 2'b10, 4'b0000, 3'b000, 1'b0);
        regDestinationAddressWB = 4'd4; reg2AddressE = 4'd4;
        applyStimulus("fwd_split", 2'b10, 2'b01, 4'b0000, 3'b000, 1'b0);
        writeEnableM = 1'b0; writeEnableWB = 1'b0;
        applyStimulus("fwd_none", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        writeEnableM = 1'b1; regDestinationAddressM = 4'd0; reg1AddressE = 4'd0;
        applyStimulus("fwd_r0_soft", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0);
        idleInputs();

        isLoadE = 1'b1; writeEnableE = 1'b1; regDestinationAddressE = 4'd5;
        reg1AddressD = 4'd5; useReg1D = 1'b1;
        applyStimulus("lw_use_rs1", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
        idleInputs();
        applyStimulus("lw_released", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        isLoadE = 1'b1; writeEnableE = 1'b1; regDestinationAddressE = 4'd5;
        reg1AddressD = 4'd2; useReg1D = 1'b1; reg2AddressD = 4'd5; useReg2D = 1'b0;
        applyStimulus("lw_unused_rs2", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        useReg2D = 1'b1;
        applyStimulus("lw_use_rs2", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
        takeBranchE = 1'b1;
        applyStimulus("branch_over_lw", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
        isLoadE = 1'b0;
        applyStimulus("branch_only", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
        idleInputs();

        memReqM = 1'b1;
        repeat (3) applyStimulus("mem_wait3", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        memReadyM = 1'b1;
        applyStimulus("mem_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        idleInputs();
        applyStimulus("mem_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        memReqM = 1'b1; memReadyM = 1'b1;
        applyStimulus("mem_fast", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        idleInputs();

        memReqM = 1'b1; takeBranchE = 1'b1; isLoadE = 1'b1;
        regDestinationAddressE = 4'd6; reg2AddressD = 4'd6; useReg2D = 1'b1;
        repeat (2) applyStimulus("mem_wait_branch", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        memReadyM = 1'b1;
        applyStimulus("branch_release", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
        idleInputs();

        memReqM = 1'b1;
        repeat (TMO) applyStimulus("timeout_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        applyStimulus("timeout_release", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        memReqM = 1'b0;
        applyStimulus("mem_error_set", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1);
        applyStimulus("mem_error_sticky", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1);
        memReqM = 1'b1; memReadyM = 1'b1;
        applyStimulus("mem_after_error", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1);
        idleInputs();
        reset = 1'b0;
        applyStimulus("mem_error_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        reset = 1'b1;
        applyStimulus("post_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

        memReqM = 1'b1;
        repeat (2) applyStimulus("wait_before_abort", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        memReqM = 1'b0; reset = 1'b0;
        applyStimulus("abort_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        reset = 1'b1;
        applyStimulus("abort_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

        memReqM = 1'b1;
        repeat (3) applyStimulus("perf_wait_a", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        memReadyM = 1'b1;
        applyStimulus("perf_ready_a", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        idleInputs();
        memReqM = 1'b1;
        repeat (2) applyStimulus("perf_wait_b", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        memReadyM = 1'b1;
        applyStimulus("perf_ready_b", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        idleInputs();
        takeBranchE = 1'b1;
        repeat (2) applyStimulus("perf_branch", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
        idleInputs();
        applyStimulus("perf_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
`ifdef HAZARD_PERF_EN
        cmp("perf_stall_total", 32'(stallCount), 32'd5);
        cmp("perf_flush_total", 32'(flushCount), 32'd2);
`else
        cmp("perf_stall_total", 32'(stallCount), 32'd0);
        cmp("perf_flush_total", 32'(flushCount), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
